step_scheduler: RTL and testbench
=================================

// Module: step_scheduler
// PURPOSE
//  Paces the snake game loop from prescaler ticks. Owns the prescaler en input, divides its 1-cycle
//  tick pulses into game steps, and issues a step_req/step_ack handshake to the game-update logic.
//  Step period shortens as food is eaten (speed levels). Sits between prescaler and game FSM.
// PARAMETERS
//  BASE_PERIOD     16'd10000  ticks per step at level 0 (0.5 s with 50 us ticks)
//  LEVEL_DEC       16'd1000   ticks removed from period per level
//  MIN_PERIOD      16'd2000   lower bound on period; must be >= 1 and <= BASE_PERIOD
//  LEVEL_W         3          width of level counter; level saturates at 2^LEVEL_W-1
//  FOODS_PER_LEVEL 4          food_eaten pulses per level increment (>= 1)
// PORTS
//  clk          in   1        system clock, 100 MHz
//  rst          in   1        synchronous reset, active high
//  tick_in      in   1        prescaler out pulse, 1 clk wide
//  start        in   1        pulse: begin/restart game
//  pause        in   1        level: hold game while high
//  food_eaten   in   1        pulse from game logic
//  game_over    in   1        pulse from game logic
//  step_ack     in   1        game logic finished current step
//  presc_en     out  1        drives prescaler en
//  step_req     out  1        step pending, held until acked
//  level        out  LEVEL_W  current speed level
//  state_dbg    out  3        FSM state encoding
//  missed_step  out  1        sticky: period elapsed while step still pending
// BEHAVIOUR
//  Reset: state IDLE; presc_en=0, step_req=0, level=0, missed_step=0, tick_cnt=0, food_cnt=0.
//  States: IDLE=0, RUN=1, WAIT_ACK=2, PAUSED=3, OVER=4. Priority: rst > game_over > start > pause > tick.
//  IDLE: presc_en=0. start -> RUN; clear level, food_cnt, tick_cnt, missed_step; latch period.
//  RUN: presc_en=1. tick_in increments 16-bit tick_cnt. tick_in with tick_cnt==period-1: tick_cnt<=0,
//   step_req<=1 next cycle, -> WAIT_ACK (latency 1 clk from final tick). pause=1 -> PAUSED, tick_cnt held.
//  WAIT_ACK: presc_en=1, ticks keep counting. step_ack -> step_req<=0, latch new period, -> RUN.
//   tick_in completing a period here: missed_step<=1, tick_cnt<=0, no second request queued.
//   step_ack and tick_in same cycle: ack handled and tick counts into new period.
//   pause ignored in WAIT_ACK; honoured in RUN after ack.
//  PAUSED: presc_en=0 (prescaler clears itself), tick_cnt/level frozen, tick_in ignored.
//   pause=0 -> RUN, counting resumes from held tick_cnt.
//  OVER: presc_en=0, step_req<=0. start -> same init as IDLE start -> RUN. step_ack ignored.
//  game_over in RUN/WAIT_ACK/PAUSED -> OVER next clk; in IDLE/OVER ignored.
//  start in RUN/WAIT_ACK/PAUSED: restart (init as above, step_req<=0, -> RUN).
//  Period: if level*LEVEL_DEC >= BASE_PERIOD-MIN_PERIOD then MIN_PERIOD else BASE_PERIOD-level*LEVEL_DEC;
//   computed at >= 32-bit width (no underflow); latched only at game start and on step_ack.
//  Level: food_eaten counted in RUN/WAIT_ACK only. food_cnt==FOODS_PER_LEVEL-1 and food_eaten:
//   food_cnt<=0, level+1 saturating at max (food_cnt still wraps).
//  missed_step cleared only by rst or game start.
// TESTING (BASE_PERIOD=4, LEVEL_DEC=1, MIN_PERIOD=2, FOODS_PER_LEVEL=2, LEVEL_W=2)
//  rst, start, 4 tick_in pulses -> presc_en=1 from cycle after start; step_req=1 one clk after 4th tick.
//  ack immediately every step, 4 food_eaten pulses -> level 0->1->2; periods 4,3,2 then stays 2
//   through level 3 (saturated, 8+ foods).
//  hold off ack across 4 more ticks -> missed_step=1, step_req stays 1 (single request), ack -> RUN.
//  after 2 ticks assert pause 10 cycles with ticks -> presc_en=0, no req; release -> req after 2 more ticks.
//  game_over during WAIT_ACK -> step_req=0, presc_en=0, state_dbg=4; start -> level=0, missed_step=0.
//  rst asserted mid-RUN with tick_in high -> all outputs at reset values next clk.

Source files
------------

// File: rtl/step_scheduler.sv
// Snake game step pacer: divides prescaler ticks into game steps and
// runs a step_req/step_ack handshake, with speed levels driven by food.
module step_scheduler #(
    parameter logic [15:0] BASE_PERIOD     = 16'd10000,
    parameter logic [15:0] LEVEL_DEC       = 16'd1000,
    parameter logic [15:0] MIN_PERIOD      = 16'd2000,
    parameter int unsigned LEVEL_W         = 3,
    parameter int unsigned FOODS_PER_LEVEL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_in,
    input  logic               start,
    input  logic               pause,
    input  logic               food_eaten,
    input  logic               game_over,
    input  logic               step_ack,
    output logic               presc_en,
    output logic               step_req,
    output logic [LEVEL_W-1:0] level,
    output logic [2:0]         state_dbg,
    output logic               missed_step
);

    localparam int unsigned FOOD_W =
        (FOODS_PER_LEVEL > 1) ? $clog2(FOODS_PER_LEVEL) : 1;
    localparam logic [FOOD_W-1:0]  FOOD_LAST = FOOD_W'(FOODS_PER_LEVEL - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        WAIT_ACK = 3'd2,
        PAUSED   = 3'd3,
        OVER     = 3'd4
    } state_t;

    // Wide arithmetic so a large level never underflows the period.
    function automatic logic [15:0] calc_period(input logic [LEVEL_W-1:0] lvl);
        logic [31:0] dec;
        logic [31:0] span;
        dec  = 32'(lvl) * 32'(LEVEL_DEC);
        span = 32'(BASE_PERIOD) - 32'(MIN_PERIOD);
        if (dec >= span) calc_period = MIN_PERIOD;
        else             calc_period = BASE_PERIOD - dec[15:0];
    endfunction

    state_t             state_q, state_d;
    logic               step_req_q, step_req_d;
    logic               missed_q, missed_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [FOOD_W-1:0]  food_q, food_d;
    logic [15:0]        tick_q, tick_d;
    logic [15:0]        period_q, period_d;
    logic               do_init;
    logic               count_food;
    logic               last_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            step_req_q <= 1'b0;
            missed_q   <= 1'b0;
            level_q    <= '0;
            food_q     <= '0;
            tick_q     <= '0;
            period_q   <= calc_period('0);
        end else begin
            state_q    <= state_d;
            step_req_q <= step_req_d;
            missed_q   <= missed_d;
            level_q    <= level_d;
            food_q     <= food_d;
            tick_q     <= tick_d;
            period_q   <= period_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_req_d = step_req_q;
        missed_d   = missed_q;
        level_d    = level_q;
        food_d     = food_q;
        tick_d     = tick_q;
        period_d   = period_q;
        do_init    = 1'b0;
        count_food = 1'b0;
        // >= rather than == so a shorter newly latched period still fires.
        last_tick  = (tick_q >= (period_q - 16'd1));

        unique case (state_q)
            IDLE: begin
                if (start) do_init = 1'b1;
            end
            RUN: begin
                if (game_over) begin
                    state_d = OVER;
                end else if (start) begin
                    do_init = 1'b1;
                end else begin
                    count_food = 1'b1;
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick_in) begin
                        if (last_tick) begin
                            tick_d     = '0;
                            step_req_d = 1'b1;
                            state_d    = WAIT_ACK;
                        end else begin
                            tick_d = tick_q + 16'd1;
                        end
                    end
                end
            end
            WAIT_ACK: begin
                if (game_over) begin
                    state_d    = OVER;
                    step_req_d = 1'b0;
                end else if (start) begin
                    do_init = 1'b1;
                end else begin
                    count_food = 1'b1;
                    if (step_ack) begin
                        step_req_d = 1'b0;
                        period_d   = calc_period(level_q);
                        state_d    = RUN;
                        if (tick_in) tick_d = last_tick ? '0 : tick_q + 16'd1;
                    end else if (tick_in) begin
                        if (last_tick) begin
                            missed_d = 1'b1;
                            tick_d   = '0;
                        end else begin
                            tick_d = tick_q + 16'd1;
                        end
                    end
                end
            end
            PAUSED: begin
                if (game_over)   state_d = OVER;
                else if (start)  do_init = 1'b1;
                else if (!pause) state_d = RUN;
            end
            OVER: begin
                step_req_d = 1'b0;
                if (start) do_init = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (count_food && food_eaten) begin
            if (food_q == FOOD_LAST) begin
                food_d = '0;
                if (level_q != LEVEL_MAX) level_d = level_q + 1'b1;
            end else begin
                food_d = food_q + 1'b1;
            end
        end

        if (do_init) begin
            state_d    = RUN;
            step_req_d = 1'b0;
            missed_d   = 1'b0;
            level_d    = '0;
            food_d     = '0;
            tick_d     = '0;
            period_d   = calc_period('0);
        end
    end

    assign presc_en    = (state_q == RUN) || (state_q == WAIT_ACK);
    assign step_req    = step_req_q;
    assign level       = level_q;
    assign state_dbg   = state_q;
    assign missed_step = missed_q;

endmodule

// File: tb/tb_step_scheduler.sv
// Scoreboard bench for step_scheduler: expected step periods are queued
// at start/ack and checked against tick counts when step_req rises.
module tb_step_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       food_eaten = 1'b0;
    logic       game_over = 1'b0;
    logic       step_ack = 1'b0;
    logic       presc_en;
    logic       step_req;
    logic [1:0] level;
    logic [2:0] state_dbg;
    logic       missed_step;

    int total = 0;
    int bad = 0;
    int q[$];
    int lvl_m = 0;
    int food_m = 0;

    step_scheduler #(
        .BASE_PERIOD(16'd4),
        .LEVEL_DEC(16'd1),
        .MIN_PERIOD(16'd2),
        .LEVEL_W(2),
        .FOODS_PER_LEVEL(2)
    ) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .start(start),
        .pause(pause), .food_eaten(food_eaten), .game_over(game_over),
        .step_ack(step_ack), .presc_en(presc_en), .step_req(step_req),
        .level(level), .state_dbg(state_dbg), .missed_step(missed_step)
    );

    always #5 clk = ~clk;

    function automatic int exp_period(input int lvl);
        if (lvl * 1 >= 4 - 2) return 2;
        return 4 - lvl;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        tick_in = 1'b1;
        cycle();
        tick_in = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
        q.delete();
        lvl_m = 0;
        food_m = 0;
        q.push_back(exp_period(0));
    endtask

    task automatic do_ack();
        step_ack = 1'b1;
        cycle();
        step_ack = 1'b0;
        q.push_back(exp_period(lvl_m));
    endtask

    task automatic do_food();
        food_eaten = 1'b1;
        cycle();
        food_eaten = 1'b0;
        food_m++;
        if (food_m == 2) begin
            food_m = 0;
            if (lvl_m < 3) lvl_m++;
        end
    endtask

    task automatic run_until_req(input int done);
        int cnt;
        int e;
        cnt = done;
        for (int i = 0; i < 20 && !step_req; i++) begin
            tick_once();
            cnt++;
        end
        total++;
        if (!step_req) begin
            bad++;
            $display("FAIL req_timeout step_req=%0d exp=1", step_req);
        end else if (q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty ticks=%0d", cnt);
        end else begin
            e = q.pop_front();
            if (cnt !== e) begin
                bad++;
                $display("FAIL step_period ticks=%0d exp=%0d", cnt, e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        total++; if (presc_en !== 1'b0) begin bad++; $display("FAIL reset_presc got=%0d exp=0", presc_en); end
        total++; if (step_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0d exp=0", step_req); end
        total++; if (level !== 2'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (missed_step !== 1'b0) begin bad++; $display("FAIL reset_missed got=%0d exp=0", missed_step); end
        total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        tick_once();
        total++; if (presc_en !== 1'b0) begin bad++; $display("FAIL idle_presc got=%0d exp=0", presc_en); end
    endtask

    task automatic test_first_step();
        do_start();
        total++; if (presc_en !== 1'b1) begin bad++; $display("FAIL start_presc got=%0d exp=1", presc_en); end
        total++; if (state_dbg !== 3'd1) begin bad++; $display("FAIL start_state got=%0d exp=1", state_dbg); end
        run_until_req(0);
        total++; if (state_dbg !== 3'd2) begin bad++; $display("FAIL first_wait got=%0d exp=2", state_dbg); end
    endtask

    task automatic test_levels();
        for (int k = 0; k < 5; k++) begin
            do_ack();
            total++; if (step_req !== 1'b0 || state_dbg !== 3'd1) begin bad++; $display("FAIL ack_run req=%0d state=%0d exp=0/1", step_req, state_dbg); end
            do_food();
            do_food();
            total++; if (level !== 2'(lvl_m)) begin bad++; $display("FAIL level k=%0d got=%0d exp=%0d", k, level, lvl_m); end
            run_until_req(0);
        end
    endtask

    task automatic test_missed();
        total++; if (missed_step !== 1'b0) begin bad++; $display("FAIL missed_pre got=%0d exp=0", missed_step); end
        repeat (4) tick_once();
        total++; if (missed_step !== 1'b1) begin bad++; $display("FAIL missed_set got=%0d exp=1", missed_step); end
        total++; if (step_req !== 1'b1 || state_dbg !== 3'd2) begin bad++; $display("FAIL missed_hold req=%0d state=%0d exp=1/2", step_req, state_dbg); end
        do_ack();
        total++; if (state_dbg !== 3'd1 || step_req !== 1'b0) begin bad++; $display("FAIL missed_ack state=%0d req=%0d exp=1/0", state_dbg, step_req); end
        total++; if (missed_step !== 1'b1) begin bad++; $display("FAIL missed_sticky got=%0d exp=1", missed_step); end
        run_until_req(0);
    endtask

    task automatic test_pause();
        do_start();
        total++; if (missed_step !== 1'b0 || level !== 2'd0) begin bad++; $display("FAIL restart missed=%0d level=%0d exp=0/0", missed_step, level); end
        total++; if (step_req !== 1'b0) begin bad++; $display("FAIL restart_req got=%0d exp=0", step_req); end
        tick_once();
        tick_once();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick_in = i[0];
            cycle();
        end
        tick_in = 1'b0;
        total++; if (presc_en !== 1'b0 || state_dbg !== 3'd3) begin bad++; $display("FAIL paused presc=%0d state=%0d exp=0/3", presc_en, state_dbg); end
        total++; if (step_req !== 1'b0) begin bad++; $display("FAIL paused_req got=%0d exp=0", step_req); end
        pause = 1'b0;
        cycle();
        total++; if (state_dbg !== 3'd1 || presc_en !== 1'b1) begin bad++; $display("FAIL resume state=%0d presc=%0d exp=1/1", state_dbg, presc_en); end
        run_until_req(2);
    endtask

    task automatic test_game_over();
        do_food();
        do_food();
        total++; if (level !== 2'(lvl_m)) begin bad++; $display("FAIL wait_food got=%0d exp=%0d", level, lvl_m); end
        repeat (4) tick_once();
        total++; if (missed_step !== 1'b1) begin bad++; $display("FAIL go_missed got=%0d exp=1", missed_step); end
        game_over = 1'b1;
        cycle();
        game_over = 1'b0;
        total++; if (step_req !== 1'b0 || presc_en !== 1'b0) begin bad++; $display("FAIL over_out req=%0d presc=%0d exp=0/0", step_req, presc_en); end
        total++; if (state_dbg !== 3'd4) begin bad++; $display("FAIL over_state got=%0d exp=4", state_dbg); end
        step_ack = 1'b1;
        cycle();
        step_ack = 1'b0;
        total++; if (state_dbg !== 3'd4) begin bad++; $display("FAIL over_ack got=%0d exp=4", state_dbg); end
        do_start();
        total++; if (level !== 2'd0 || missed_step !== 1'b0) begin bad++; $display("FAIL over_restart level=%0d missed=%0d exp=0/0", level, missed_step); end
        total++; if (state_dbg !== 3'd1) begin bad++; $display("FAIL over_run got=%0d exp=1", state_dbg); end
    endtask

    task automatic test_back_to_back();
        run_until_req(0);
        step_ack = 1'b1;
        tick_in = 1'b1;
        cycle();
        step_ack = 1'b0;
        tick_in = 1'b0;
        q.push_back(exp_period(lvl_m));
        total++; if (state_dbg !== 3'd1 || step_req !== 1'b0) begin bad++; $display("FAIL ack_tick state=%0d req=%0d exp=1/0", state_dbg, step_req); end
        run_until_req(1);
    endtask

    task automatic test_rst_mid_run();
        do_ack();
        tick_once();
        rst = 1'b1;
        tick_in = 1'b1;
        cycle();
        rst = 1'b0;
        tick_in = 1'b0;
        q.delete();
        total++; if (state_dbg !== 3'd0 || presc_en !== 1'b0) begin bad++; $display("FAIL rst_run state=%0d presc=%0d exp=0/0", state_dbg, presc_en); end
        total++; if (step_req !== 1'b0 || level !== 2'd0 || missed_step !== 1'b0) begin bad++; $display("FAIL rst_run_out req=%0d level=%0d missed=%0d exp=0", step_req, level, missed_step); end
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_levels();
        test_missed();
        test_pause();
        test_game_over();
        test_back_to_back();
        test_rst_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
